alu_exec_unit: RTL and testbench
================================

Name: alu_exec_unit

Overview:
Multi-cycle integer execution unit that consumes the 5-bit ALU control code and Sign bit produced by the ALU controller, together with two operands, and returns a result with flags.
- Sits in the EX stage of the multi-cycle datapath, between the register-file/immediate muxes and the write-back/branch logic.
- Uses valid/ready handshakes on both sides.
- Shifts are executed iteratively, one bit per cycle, unless the fast-shift option is compiled in.

Parameters:
WIDTH, 32, operand/result width; shift amount is always in_a[4:0], so WIDTH must be 32.

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
in_valid  input  1  operation request valid
in_ready  output  1  unit can accept a request
alu_ctrl  input  5  operation code (encoding below)
sign  input  1  1 = signed semantics, 0 = unsigned
in_a  input  WIDTH  operand A; for shifts, shift amount = in_a[4:0]
in_b  input  WIDTH  operand B; for shifts, value being shifted
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
result  output  WIDTH  operation result
zero  output  1  result == 0
overflow  output  1  signed add/sub overflow
illegal  output  1  alu_ctrl not in the defined set

Behaviour:
- Encoding:
  - 0 add, 1 sub, 2 and, 3 or, 4 xor, 5 nor
  - 6 sll, 7 srl, 8 sra, 9 slt
  - 10..31 illegal
- Reset (asynchronous, any state, including mid-shift): state IDLE, in_ready=1, out_valid=0, result=0, zero=0, overflow=0, illegal=0. Any in-flight operation is discarded.
- States:
  - IDLE: in_ready=1.
  - SHIFT: in_ready=0, out_valid=0.
  - DONE: in_ready=0, out_valid=1.
- Accept: handshake occurs when in_valid && in_ready. alu_ctrl, sign, in_a and in_b are registered on that edge; later input changes are ignored.
- IDLE transitions on accept:
  - Non-shift or illegal op: result computed, go to DONE. Latency 1 cycle from accept to out_valid.
  - Shift with shamt=0: result=in_b, go to DONE. Latency 1.
  - Shift with shamt>0: load a working register with in_b and a counter with shamt, go to SHIFT.
- SHIFT, each cycle:
  - Shift the working register by 1: sll fills 0; srl fills 0; sra fills with the MSB.
  - Decrement the counter.
  - When the counter reaches 0 after this step, go to DONE.
  - Total latency = shamt cycles from accept to out_valid (shamt=31 gives 31 cycles).
  - sign has no effect on shifts.
- DONE:
  - result and flags are held stable while out_valid=1 && !out_ready.
  - On out_ready, go to IDLE. out_valid drops on the next edge; result and flags keep their last values.
  - A new request is therefore accepted no earlier than one cycle after the result handshake. Maximum throughput is one op per 2 cycles.
- Arithmetic:
  - add/sub: modulo 2^WIDTH.
  - overflow=1 only when sign=1 and signed overflow occurs (operand signs equal and result sign differs for add; operand signs differ and result sign differs from A for sub). Otherwise overflow=0.
  - slt: result = {31'b0, A<B}, using a signed compare when sign=1 and an unsigned compare when sign=0.
  - and/or/xor/nor: bitwise; sign ignored.
  - illegal: result=0, illegal=1, zero=1, overflow=0.
- zero is computed from the final result and is valid whenever out_valid=1.
- in_valid asserted while in_ready=0: no effect; the requester must hold the request.

Optional Feature:
ALU_FAST_SHIFT_EN
- Defined: shifts use a combinational barrel shifter, the SHIFT state is not used, and every op (all shamt values) has latency 1.
- Undefined: the iterative shifter described above is used.
- Results and flags are identical in both builds; only latency differs.

Test Plan:
- Reset asserted mid-shift (sll, shamt=20, after 5 cycles) -> immediately out_valid=0, in_ready=1, result=0; the next op add 1+1 returns 2.
- add, sign=1, A=0x7FFFFFFF, B=1 -> 1 cycle later result=0x80000000, overflow=1, zero=0. Same operands with sign=0 -> overflow=0.
- sub, A=B=0x12345678 -> result=0, zero=1. slt sign=1, A=0xFFFFFFFF, B=1 -> result=1; sign=0 -> result=0.
- sra, in_a=4, in_b=0x80000000 -> out_valid exactly 4 cycles after accept, result=0xF8000000. srl, shamt=0, in_b=0xABCD -> 1 cycle, result=0xABCD.
- Backpressure: out_ready=0 for 6 cycles after xor 0xFF00FF00^0x0F0F0F0F -> result holds 0xF00FF00F, in_ready=0 throughout. Raising out_ready -> IDLE on the next edge.
- alu_ctrl=5'd17 -> illegal=1, result=0, zero=1. With ALU_FAST_SHIFT_EN defined, sll shamt=31, in_b=1 -> 1 cycle, result=0x80000000.

Source files
------------

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: multi-cycle integer execution unit for the EX stage.
//
// Takes the 5-bit ALU control code and sign bit from the ALU controller plus
// two operands. It returns a result with zero/overflow/illegal flags. Both
// sides use valid/ready handshakes. One operation is in flight at a time.
//
// Ports:
//   clk, reset          rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready   request handshake (alu_ctrl, sign, in_a, in_b)
//   alu_ctrl            0 add, 1 sub, 2 and, 3 or, 4 xor, 5 nor,
//                       6 sll, 7 srl, 8 sra, 9 slt, 10..31 illegal
//   sign                signed semantics for overflow and slt
//   in_a, in_b          operands; shifts move in_b by in_a[4:0]
//   out_valid/out_ready result handshake
//   result, zero, overflow, illegal  registered result and flags
//
// Build option:
//   ALU_FAST_SHIFT_EN   when defined, shifts use a combinational barrel
//                       shifter and every op completes one cycle after accept.
//                       When undefined, shifts move one bit per cycle.
module alu_exec_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       alu_ctrl,
    input  logic             sign,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             overflow,
    output logic             illegal
);

    localparam logic [4:0] OP_ADD = 5'd0, OP_SUB = 5'd1, OP_AND = 5'd2,
                           OP_OR  = 5'd3, OP_XOR = 5'd4, OP_NOR = 5'd5,
                           OP_SLL = 5'd6, OP_SRL = 5'd7, OP_SRA = 5'd8,
                           OP_SLT = 5'd9;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    state_t state;

    logic [4:0]       shamt;
    logic [WIDTH-1:0] sum, diff, calc;
    logic             calc_ovf, calc_ill, lt;

    assign shamt = in_a[4:0];
    assign sum   = in_a + in_b;
    assign diff  = in_a - in_b;
    assign lt    = sign ? ($signed(in_a) < $signed(in_b)) : (in_a < in_b);

    // Single-cycle result, computed from the request inputs so it can be
    // registered on the accept edge.
    always_comb begin
        calc     = '0;
        calc_ovf = 1'b0;
        calc_ill = 1'b0;
        case (alu_ctrl)
            OP_ADD: begin
                calc     = sum;
                calc_ovf = sign && (in_a[WIDTH-1] == in_b[WIDTH-1])
                                && (sum[WIDTH-1] != in_a[WIDTH-1]);
            end
            OP_SUB: begin
                calc     = diff;
                calc_ovf = sign && (in_a[WIDTH-1] != in_b[WIDTH-1])
                                && (diff[WIDTH-1] != in_a[WIDTH-1]);
            end
            OP_AND: calc = in_a & in_b;
            OP_OR:  calc = in_a | in_b;
            OP_XOR: calc = in_a ^ in_b;
            OP_NOR: calc = ~(in_a | in_b);
            OP_SLT: calc = {{(WIDTH-1){1'b0}}, lt};
`ifdef ALU_FAST_SHIFT_EN
            OP_SLL: calc = in_b << shamt;
            OP_SRL: calc = in_b >> shamt;
            OP_SRA: calc = $unsigned($signed(in_b) >>> shamt);
`else
            // Only reached here with shamt == 0; nonzero amounts take SHIFT.
            OP_SLL, OP_SRL, OP_SRA: calc = in_b;
`endif
            default: calc_ill = 1'b1;
        endcase
    end

`ifndef ALU_FAST_SHIFT_EN
    logic [WIDTH-1:0] work, work_nxt, first_step;
    logic [4:0]       cnt, sh_op;
    logic             is_shift;

    function automatic logic [WIDTH-1:0] step1(input logic [4:0] op,
                                               input logic [WIDTH-1:0] v);
        case (op)
            OP_SLL:  step1 = {v[WIDTH-2:0], 1'b0};
            OP_SRL:  step1 = {1'b0, v[WIDTH-1:1]};
            default: step1 = {v[WIDTH-1], v[WIDTH-1:1]};
        endcase
    endfunction

    assign is_shift   = (alu_ctrl == OP_SLL) || (alu_ctrl == OP_SRL) ||
                        (alu_ctrl == OP_SRA);
    assign first_step = step1(alu_ctrl, in_b);
    assign work_nxt   = step1(sh_op, work);
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            result    <= '0;
            zero      <= 1'b0;
            overflow  <= 1'b0;
            illegal   <= 1'b0;
`ifndef ALU_FAST_SHIFT_EN
            work      <= '0;
            cnt       <= '0;
            sh_op     <= '0;
`endif
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    in_ready <= 1'b0;
`ifndef ALU_FAST_SHIFT_EN
                    // The accept edge performs the first shift step, so the
                    // result appears exactly shamt cycles after accept.
                    if (is_shift && shamt > 5'd1) begin
                        work  <= first_step;
                        cnt   <= shamt - 5'd1;
                        sh_op <= alu_ctrl;
                        state <= SHIFT;
                    end else if (is_shift && shamt == 5'd1) begin
                        result    <= first_step;
                        zero      <= (first_step == '0);
                        overflow  <= 1'b0;
                        illegal   <= 1'b0;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else
`endif
                    begin
                        result    <= calc;
                        zero      <= (calc == '0);
                        overflow  <= calc_ovf;
                        illegal   <= calc_ill;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
`ifndef ALU_FAST_SHIFT_EN
                SHIFT: begin
                    work <= work_nxt;
                    cnt  <= cnt - 5'd1;
                    if (cnt == 5'd1) begin
                        result    <= work_nxt;
                        zero      <= (work_nxt == '0);
                        overflow  <= 1'b0;
                        illegal   <= 1'b0;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
`endif
                DONE: if (out_ready) begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= IDLE;
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: a table of vectors run through a
// scoreboard queue, then hand sequences for backpressure and mid-shift reset.
module tb_alu_exec_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0, in_ready;
    logic [4:0]  alu_ctrl = '0;
    logic        sign = 1'b0;
    logic [31:0] in_a = '0, in_b = '0;
    logic        out_valid, out_ready = 1'b1;
    logic [31:0] result;
    logic        zero, overflow, illegal;

    alu_exec_unit #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .alu_ctrl(alu_ctrl), .sign(sign), .in_a(in_a), .in_b(in_b),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .zero(zero), .overflow(overflow), .illegal(illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [4:0]  ctrl;
        logic        sgn;
        logic [31:0] a, b, res;
        logic        z, ov, il;
        int          lat;
    } vec_t;

    vec_t vt[20];
    vec_t sb[$];
    int   nvec = 0, nerr = 0;

    function automatic vec_t mk(string nm, logic [4:0] c, logic s, logic [31:0] a,
                                logic [31:0] b, logic [31:0] r, logic z, logic ov,
                                logic il, int lat);
        vec_t v;
        v.name = nm; v.ctrl = c; v.sgn = s; v.a = a; v.b = b; v.res = r;
        v.z = z; v.ov = ov; v.il = il; v.lat = lat;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic wait_ready();
        for (int w = 0; w < 200 && in_ready !== 1'b1; w++) @(posedge clk) #1;
    endtask

    // Drive one request; push its expectation; scramble inputs after accept.
    task automatic drive(input vec_t v);
        vec_t e;
        wait_ready();
        alu_ctrl = v.ctrl; sign = v.sgn; in_a = v.a; in_b = v.b; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_a = $urandom; in_b = $urandom; alu_ctrl = 5'($urandom); sign = 1'($urandom);
        e = v;
`ifdef ALU_FAST_SHIFT_EN
        e.lat = 1;
`endif
        sb.push_back(e);
    endtask

    // Wait for out_valid (bounded), pop the scoreboard and compare.
    task automatic collect();
        int   lat;
        vec_t e;
        lat = 1;
        while (out_valid !== 1'b1 && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        if (sb.size() == 0) begin
            nvec++; nerr++;
            $display("FAIL scoreboard: got output with empty queue, expected an entry");
            return;
        end
        e = sb.pop_front();
        chk({e.name, " out_valid"}, 32'(out_valid), 32'd1);
        chk({e.name, " latency"}, lat, e.lat);
        chk({e.name, " result"}, result, e.res);
        chk({e.name, " zero"}, 32'(zero), 32'(e.z));
        chk({e.name, " overflow"}, 32'(overflow), 32'(e.ov));
        chk({e.name, " illegal"}, 32'(illegal), 32'(e.il));
    endtask

    initial begin
        vt[0]  = mk("add ovf s1",  5'd0, 1, 32'h7FFFFFFF, 32'h1, 32'h80000000, 0, 1, 0, 1);
        vt[1]  = mk("add s0",      5'd0, 0, 32'h7FFFFFFF, 32'h1, 32'h80000000, 0, 0, 0, 1);
        vt[2]  = mk("add wrap s1", 5'd0, 1, 32'h80000000, 32'h80000000, 32'h0, 1, 1, 0, 1);
        vt[3]  = mk("sub eq",      5'd1, 1, 32'h12345678, 32'h12345678, 32'h0, 1, 0, 0, 1);
        vt[4]  = mk("sub ovf s1",  5'd1, 1, 32'h80000000, 32'h1, 32'h7FFFFFFF, 0, 1, 0, 1);
        vt[5]  = mk("sub s0",      5'd1, 0, 32'h80000000, 32'h1, 32'h7FFFFFFF, 0, 0, 0, 1);
        vt[6]  = mk("and",         5'd2, 0, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 0, 0, 0, 1);
        vt[7]  = mk("or",          5'd3, 1, 32'h1, 32'h2, 32'h3, 0, 0, 0, 1);
        vt[8]  = mk("xor",         5'd4, 0, 32'hFF00FF00, 32'h0F0F0F0F, 32'hF00FF00F, 0, 0, 0, 1);
        vt[9]  = mk("nor",         5'd5, 0, 32'h0, 32'h0, 32'hFFFFFFFF, 0, 0, 0, 1);
        vt[10] = mk("slt s1",      5'd9, 1, 32'hFFFFFFFF, 32'h1, 32'h1, 0, 0, 0, 1);
        vt[11] = mk("slt s0",      5'd9, 0, 32'hFFFFFFFF, 32'h1, 32'h0, 1, 0, 0, 1);
        vt[12] = mk("slt s1 neg b",5'd9, 1, 32'h1, 32'hFFFFFFFF, 32'h0, 1, 0, 0, 1);
        vt[13] = mk("sra 4",       5'd8, 0, 32'h4, 32'h80000000, 32'hF8000000, 0, 0, 0, 4);
        vt[14] = mk("srl 0",       5'd7, 0, 32'h0, 32'h0000ABCD, 32'h0000ABCD, 0, 0, 0, 1);
        vt[15] = mk("srl 1",       5'd7, 1, 32'h1, 32'h80000000, 32'h40000000, 0, 0, 0, 1);
        vt[16] = mk("sll 8",       5'd6, 0, 32'h8, 32'h000000AB, 32'h0000AB00, 0, 0, 0, 8);
        vt[17] = mk("sra a=36",    5'd8, 1, 32'h24, 32'h7FFFFFF0, 32'h07FFFFFF, 0, 0, 0, 4);
        vt[18] = mk("sll 31",      5'd6, 0, 32'h1F, 32'h1, 32'h80000000, 0, 0, 0, 31);
        vt[19] = mk("illegal 17",  5'd17, 1, 32'h5, 32'h7, 32'h0, 1, 0, 1, 1);

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("reset in_ready", 32'(in_ready), 32'd1);
        chk("reset out_valid", 32'(out_valid), 32'd0);
        chk("reset result", result, 32'h0);
        chk("reset flags", {29'd0, zero, overflow, illegal}, 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Table vectors; each result is acknowledged on the next edge.
        for (int i = 0; i < 20; i++) begin
            drive(vt[i]);
            collect();
            @(posedge clk); #1;
            chk({vt[i].name, " ack idle"}, {30'd0, out_valid, in_ready}, 32'd1);
        end

        // Backpressure: result held and no new accept while out_ready is low.
        out_ready = 1'b0;
        drive(vt[8]);
        collect();
        in_valid = 1'b1; alu_ctrl = 5'd0; in_a = 32'h1; in_b = 32'h1;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            chk("bp result hold", result, 32'hF00FF00F);
            chk("bp valid/ready", {30'd0, out_valid, in_ready}, 32'd2);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp release valid/ready", {30'd0, out_valid, in_ready}, 32'd1);
        chk("bp release result kept", result, 32'hF00FF00F);

        // Reset mid-shift: sll by 20, reset 5 cycles after accept.
        wait_ready();
        alu_ctrl = 5'd6; sign = 1'b0; in_a = 32'd20; in_b = 32'h1; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1 reset = 1'b1;
        #1;
        chk("mid-shift reset valid/ready", {30'd0, out_valid, in_ready}, 32'd1);
        chk("mid-shift reset result", result, 32'h0);
        #2 reset = 1'b0;
        @(posedge clk); #1;
        chk("post reset still idle", {30'd0, out_valid, in_ready}, 32'd1);
        drive(mk("add after reset", 5'd0, 0, 32'h1, 32'h1, 32'h2, 0, 0, 0, 1));
        collect();
        @(posedge clk); #1;

        if (sb.size() != 0) begin
            nvec++; nerr++;
            $display("FAIL scoreboard drain: got %0d pending, expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
